// File: rtl/count_snapshot_pkg.sv
// Shared definitions for the count snapshot FIFO: register map, CTRL/STATUS bit
// positions and capture mode encodings.
package count_snapshot_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_STATUS = 2'd1,
        REG_DATA   = 2'd2,
        REG_PERIOD = 2'd3
    } reg_e;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_MODE       = 1;
    localparam int CTRL_CLEAR      = 2;
    localparam int CTRL_THRESH_LSB = 4;

    localparam int STATUS_EMPTY    = 8;
    localparam int STATUS_FULL     = 9;
    localparam int STATUS_OVERFLOW = 10;

    typedef enum logic {
        MODE_TRIG     = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a pushed entry becomes visible at the head on the
// following cycle (no write-to-read bypass).
module sync_fifo #(
    parameter int BITS  = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [BITS-1:0] wdata,
    output logic [BITS-1:0] rdata,
    output logic            full,
    output logic            empty,
    output logic [AW:0]     level
);

    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; pointers and level define validity,
    // and leaving it unreset lets it map onto plain RAM or flops without reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/count_snapshot_fifo.sv
// Wishbone slave that snapshots count_i on a trigger edge or a programmable period,
// queues the snapshots for firmware and raises a level-threshold interrupt.
module count_snapshot_fifo
    import count_snapshot_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] count_i,
    input  logic            trig_i,
    output logic            irq_o
);

    reg_e            reg_idx;
    logic            access;
    logic            wr_access;
    logic            rd_access;
    logic            ctrl_en;
    mode_e           ctrl_mode;
    logic [3:0]      ctrl_thresh;
    logic [31:0]     period;
    logic [31:0]     prescaler;
    logic            overflow;
    logic            trig_q;
    logic            ctrl_wr;
    logic            clear;
    logic            en_fall;
    logic            status_w1c;
    logic            pop;
    logic            trig_edge;
    logic            period_hit;
    logic            capture;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [AW:0]     fifo_level;
    logic [BITS-1:0] fifo_head;
    logic [31:0]     rd_data;
    logic            unused_adr;

    assign unused_adr = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // The access strobe is one cycle wide: while ack is high a held request is ignored.
    assign reg_idx   = reg_e'(wbs_adr_i[3:2]);
    assign access    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_access = access & wbs_we_i;
    assign rd_access = access & ~wbs_we_i;

    assign ctrl_wr    = wr_access && (reg_idx == REG_CTRL) && wbs_sel_i[0];
    assign clear      = ctrl_wr && wbs_dat_i[CTRL_CLEAR];
    assign en_fall    = ctrl_wr && ctrl_en && !wbs_dat_i[CTRL_EN];
    assign status_w1c = wr_access && (reg_idx == REG_STATUS) && wbs_sel_i[1]
                        && wbs_dat_i[STATUS_OVERFLOW];
    assign pop        = rd_access && (reg_idx == REG_DATA);

    assign trig_edge  = trig_i & ~trig_q;
    // Using >= also recovers cleanly when PERIOD is lowered below the running count.
    assign period_hit = (period != '0) && (prescaler >= period - 32'd1);
    assign capture    = ctrl_en && ((ctrl_mode == MODE_TRIG) ? trig_edge : period_hit);
    assign drop       = capture && fifo_full && !pop;

    sync_fifo #(
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n_i),
        .push  (capture),
        .pop   (pop),
        .flush (clear),
        .wdata (count_i),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave it unassigned and infer a latch.
        rd_data = '0;
        case (reg_idx)
            REG_CTRL: begin
                rd_data[CTRL_EN]                          = ctrl_en;
                rd_data[CTRL_MODE]                        = ctrl_mode;
                rd_data[CTRL_THRESH_LSB +: 4]             = ctrl_thresh;
            end
            REG_STATUS: begin
                rd_data[AW:0]            = fifo_level;
                rd_data[STATUS_EMPTY]    = fifo_empty;
                rd_data[STATUS_FULL]     = fifo_full;
                rd_data[STATUS_OVERFLOW] = overflow;
            end
            REG_DATA:   rd_data = fifo_empty ? '0 : 32'(fifo_head);
            REG_PERIOD: rd_data = period;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            wbs_dat_o <= rd_access ? rd_data : '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ctrl_en     <= 1'b0;
            ctrl_mode   <= MODE_TRIG;
            ctrl_thresh <= '0;
            period      <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en     <= wbs_dat_i[CTRL_EN];
                ctrl_mode   <= mode_e'(wbs_dat_i[CTRL_MODE]);
                ctrl_thresh <= wbs_dat_i[CTRL_THRESH_LSB +: 4];
            end
            if (wr_access && (reg_idx == REG_PERIOD)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) period[8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            prescaler <= '0;
            overflow  <= 1'b0;
            trig_q    <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            trig_q <= trig_i;
            irq_o  <= (ctrl_thresh != 4'd0) && (32'(fifo_level) >= 32'(ctrl_thresh));

            if (clear || en_fall || period == '0) begin
                prescaler <= '0;
            end else if (ctrl_en && ctrl_mode == MODE_PERIODIC) begin
                prescaler <= period_hit ? '0 : prescaler + 32'd1;
            end

            // A flush wins over a same-cycle drop, so a clear always leaves overflow low.
            if (clear) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end else if (status_w1c) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench for count_snapshot_fifo: register access, trigger and periodic
// capture, overflow, threshold interrupt and the full/clear corner cases.
module tb_count_snapshot_fifo;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_STATUS = 2'd1;
    localparam logic [1:0] R_DATA   = 2'd2;
    localparam logic [1:0] R_PERIOD = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [31:0] count_sig;
    logic        trig;
    logic        irq;

    logic [31:0] tb_cnt = '0;
    logic [31:0] man_cnt;
    logic        auto_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic [31:0] ent [5];

    always #5 clk = ~clk;
    always @(posedge clk) tb_cnt <= tb_cnt + 32'd1;
    assign count_sig = auto_cnt ? tb_cnt : man_cnt;

    count_snapshot_fifo dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .count_i    (count_sig),
        .trig_i     (trig),
        .irq_o      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One Wishbone transfer: request driven at a falling edge, ack expected right
    // after the next rising edge, then one idle edge so ack can drop.
    task automatic wb_xfer(input logic wr, input logic [1:0] idx, input logic [31:0] data,
                           input logic [3:0] lanes, input logic with_trig,
                           output logic [31:0] result);
        @(negedge clk);
        check("ack_idle", 32'(ack), 32'd0);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = wr;
        adr  = {28'd0, idx, 2'b00};
        wdat = data;
        sel  = lanes;
        if (with_trig) trig = 1'b1;
        @(posedge clk);
        #1;
        check("ack_rise", 32'(ack), 32'd1);
        result = rdat;
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        trig = 1'b0;
        @(posedge clk);
    endtask

    task automatic wb_write(input logic [1:0] idx, input logic [31:0] data);
        logic [31:0] dummy;
        wb_xfer(1'b1, idx, data, 4'hF, 1'b0, dummy);
    endtask

    task automatic wb_read(input logic [1:0] idx, output logic [31:0] data);
        wb_xfer(1'b0, idx, 32'd0, 4'hF, 1'b0, data);
    endtask

    task automatic pulse_trig(input logic [31:0] value);
        @(negedge clk);
        man_cnt = value;
        trig    = 1'b1;
        @(negedge clk);
        trig    = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        cyc      = 1'b0;
        stb      = 1'b0;
        we       = 1'b0;
        sel      = 4'h0;
        adr      = '0;
        wdat     = '0;
        trig     = 1'b0;
        man_cnt  = '0;
        auto_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_dat", rdat, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state seen through STATUS; ack is a single cycle
        wb_read(R_STATUS, rd);
        check("t1_status", rd, 32'h0000_0100);
        #1;
        check("t1_ack_drop", 32'(ack), 32'd0);
        check("t1_irq", 32'(irq), 32'd0);

        // Trigger-edge capture, drain in order, then an empty read
        wb_write(R_CTRL, 32'h0000_0001);
        pulse_trig(32'h10);
        pulse_trig(32'h20);
        pulse_trig(32'h30);
        wb_read(R_STATUS, rd);
        check("t2_level3", rd, 32'h0000_0003);
        wb_read(R_DATA, rd);
        check("t2_data0", rd, 32'h10);
        wb_read(R_DATA, rd);
        check("t2_data1", rd, 32'h20);
        wb_read(R_DATA, rd);
        check("t2_data2", rd, 32'h30);
        wb_read(R_DATA, rd);
        check("t2_empty_read", rd, 32'h0);
        wb_read(R_STATUS, rd);
        check("t2_status", rd, 32'h0000_0100);

        // Periodic capture: PERIOD=4 over exactly 20 enabled cycles
        auto_cnt = 1'b1;
        wb_write(R_PERIOD, 32'd4);
        wb_write(R_CTRL, 32'h0000_0007);
        repeat (18) @(posedge clk);
        wb_write(R_CTRL, 32'h0000_0002);
        auto_cnt = 1'b0;
        wb_read(R_STATUS, rd);
        check("t3_level5", rd, 32'h0000_0005);
        for (int i = 0; i < 5; i++) begin
            wb_read(R_DATA, rd);
            ent[i] = rd;
        end
        for (int i = 0; i < 4; i++) begin
            check("t3_delta", ent[i+1] - ent[i], 32'd4);
        end
        wb_read(R_DATA, rd);
        check("t3_sixth_read", rd, 32'h0);

        // Threshold interrupt at level 3, released by one pop
        wb_write(R_CTRL, 32'h0000_0035);
        pulse_trig(32'h51);
        pulse_trig(32'h52);
        repeat (2) @(posedge clk);
        #1;
        check("t5_irq_lvl2", 32'(irq), 32'd0);
        pulse_trig(32'h53);
        check("t5_irq_same_cycle", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        check("t5_irq_lvl3", 32'(irq), 32'd1);
        wb_read(R_DATA, rd);
        check("t5_pop_data", rd, 32'h51);
        #1;
        check("t5_irq_after_pop", 32'(irq), 32'd0);

        // Ten triggers into an eight-deep FIFO: full, sticky overflow, then W1C
        wb_write(R_CTRL, 32'h0000_0005);
        for (int i = 0; i < 10; i++) begin
            pulse_trig(32'hA0 + 32'(i));
        end
        wb_read(R_STATUS, rd);
        check("t4_full_ovf", rd, 32'h0000_0608);
        check("t4_irq_thresh0", 32'(irq), 32'd0);
        wb_write(R_STATUS, 32'h0000_0400);
        wb_read(R_STATUS, rd);
        check("t4_w1c", rd, 32'h0000_0208);

        // Pop and push on the same edge while full: level holds, no overflow
        man_cnt = 32'hB0;
        wb_xfer(1'b0, R_DATA, 32'd0, 4'hF, 1'b1, rd);
        check("t6_pop_head", rd, 32'hA0);
        wb_read(R_STATUS, rd);
        check("t6_status", rd, 32'h0000_0208);
        for (int i = 1; i < 8; i++) begin
            wb_read(R_DATA, rd);
            check("t6_kept", rd, 32'hA0 + 32'(i));
        end
        wb_read(R_STATUS, rd);
        check("t6_level1", rd, 32'h0000_0001);
        man_cnt = 32'hC0;
        wb_xfer(1'b1, R_CTRL, 32'h0000_0005, 4'hF, 1'b1, rd);
        wb_read(R_STATUS, rd);
        check("t6_clear_wins", rd, 32'h0000_0100);

        // Reset during a pending request: no ack, FIFO emptied
        pulse_trig(32'hD0);
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b0;
        adr   = {28'd0, R_DATA, 2'b00};
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_ack", 32'(ack), 32'd0);
        check("rst_mid_dat", rdat, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 1'b0;
        stb   = 1'b0;
        wb_read(R_STATUS, rd);
        check("rst_mid_status", rd, 32'h0000_0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
